rr_reg_arbiter: RTL
===================

// Module: rr_reg_arbiter
// PURPOSE
//  Round-robin write arbiter for one shared WIDTH-bit flip-flop register.
//  N requesters compete for write access; at most one write per clock.
//  Optional bounded lock gives a requester back-to-back writes.
//  Sits between client blocks and the shared register it owns.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  WIDTH     8   register / write-data width in bits
//  MAX_LOCK  8   max consecutive locked grants before forced release (>=1)
// PORTS
//  clk      in   1          clock; all state updates on rising edge
//  reset    in   1          synchronous, active-high reset
//  req      in   N          req[i]=1: requester i wants to write this cycle
//  lock     in   N          lock[i]=1 with req[i]: keep ownership next cycle
//  wdata    in   N*WIDTH    wdata[i*WIDTH +: WIDTH] = data of requester i
//  gnt      out  N          one-hot; gnt[i]=1: wdata[i] was written at last edge
//  owner    out  clog2(N)   index of last granted requester
//  q        out  WIDTH      shared register contents
//  q_valid  out  1          1 once any write has occurred since reset
//  locked   out  1          1 while FSM is in LOCKED
// BEHAVIOUR
//  Reset (sync, dominates all inputs): q=0, gnt=0, owner=0, q_valid=0,
//   locked=0, ptr=0, lock_cnt=0, state=IDLE.
//  Internal: ptr (clog2(N)) = highest-priority index; lock_cnt counts locked grants.
//  IDLE: winner w = first i with req[i]=1 scanning ptr, ptr+1, ... mod N.
//   Any req at edge: q<=wdata[w], gnt<=onehot(w), owner<=w, q_valid<=1,
//   ptr<=(w+1) mod N. If lock[w]=1 and MAX_LOCK>1: state<=LOCKED, lock_cnt<=1.
//   No req: gnt<=0; q, owner, ptr, q_valid hold.
//  LOCKED (owner o): only o is considered; other reqs ignored (no gnt).
//   req[o]=1: write wdata[o], gnt<=onehot(o), lock_cnt<=lock_cnt+1.
//   Stay LOCKED if lock[o]=1 and lock_cnt+1<MAX_LOCK; else state<=IDLE.
//   req[o]=0: no write, gnt<=0, state<=IDLE in that same edge; lock_cnt<=0.
//   ptr stays (o+1) mod N throughout lock -> fairness resumes on release.
//  Latency: req sampled at edge k -> q and gnt updated at edge k (visible
//   cycle k+1); gnt is a single-cycle pulse per write.
//  Fairness: all N requesting, no lock -> each granted exactly once per N cycles.
//  Wrap: ptr from N-1 -> 0; winner search wraps modulo N.
//  lock[i] without req[i] is ignored; lock of a non-winner is ignored.
//  Reset mid-lock: returns to IDLE, ptr=0, q cleared the same edge.
//  q holds its value indefinitely when no write occurs.
// TESTING
//  1 reset=1 with req=4'b1111 for 2 cycles -> q=0, gnt=0, q_valid=0, owner=0.
//  2 N=4, req=4'b1111, wdata={8'h44,8'h33,8'h22,8'h11}, no lock, 8 cycles
//    -> gnt order 0001,0010,0100,1000,0001...; q 11,22,33,44,11...
//  3 single req[2] pulse with wdata[2]=8'hA5 -> next cycle gnt=0100, owner=2,
//    q=A5, q_valid=1; then req=0 -> gnt=0, q stays A5.
//  4 req[1]+lock[1] held 12 cycles, req[3] also held -> gnt[1] for 8 cycles
//    (MAX_LOCK), locked=1 during, then gnt[3] granted next cycle.
//  5 LOCKED on 1, req[1] drops while req[0] held -> no write that edge,
//    locked=0; following cycle gnt=1000? no: ptr=2, only req[0] -> gnt=0001.
//  6 reset asserted mid-lock -> next cycle locked=0, q=0, ptr=0; with
//    req=4'b1010 after release -> gnt=0010 first.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin write arbiter owning one shared WIDTH-bit register,
// with a bounded lock that grants one requester back-to-back writes. Rev 1.0
`default_nettype none

module rr_reg_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N*WIDTH-1:0]     wdata,
  output logic [N-1:0]           gnt,
  output logic [$clog2(N)-1:0]   owner,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   locked
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [CW-1:0]     lock_cnt, lock_cnt_nxt;
  logic [CW:0]       cnt_inc;
  logic [N-1:0]      gnt_nxt;
  logic [PW-1:0]     owner_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic              q_valid_nxt;

  logic              found;
  logic [PW-1:0]     winner;
  logic [PW:0]       idx;

  logic [WIDTH-1:0]  wdata_arr [N];

  generate
    for (genvar i = 0; i < N; i++) begin : g_unpack
      assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan ptr, ptr+1, ... modulo N; the first requester seen wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  assign cnt_inc = {1'b0, lock_cnt} + (CW+1)'(1);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_cnt_nxt = lock_cnt;
    gnt_nxt      = '0;
    owner_nxt    = owner;
    q_nxt        = q;
    q_valid_nxt  = q_valid;

    unique case (state)
      IDLE: begin
        if (found) begin
          q_nxt       = wdata_arr[winner];
          gnt_nxt     = {{(N-1){1'b0}}, 1'b1} << winner;
          owner_nxt   = winner;
          q_valid_nxt = 1'b1;
          ptr_nxt     = (winner == PW'(N-1)) ? '0 : winner + PW'(1);
          if (lock[winner] && (MAX_LOCK > 1)) begin
            state_nxt    = LOCKED;
            lock_cnt_nxt = CW'(1);
          end
        end
      end
      LOCKED: begin
        // Only the owner is served; ptr already points past it for release.
        if (req[owner]) begin
          q_nxt        = wdata_arr[owner];
          gnt_nxt      = {{(N-1){1'b0}}, 1'b1} << owner;
          lock_cnt_nxt = cnt_inc[CW-1:0];
          if (!(lock[owner] && (cnt_inc < (CW+1)'(MAX_LOCK)))) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end
        end else begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_cnt <= '0;
      gnt      <= '0;
      owner    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_cnt <= lock_cnt_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      q        <= q_nxt;
      q_valid  <= q_valid_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

`default_nettype wire
